// File: rtl/vedic_pkg.sv
// Shared constants and FSM state type for the Vedic product accumulator.
// Optional feature macro: VEDIC_ACC_SAT_EN (saturating accumulation).
package vedic_pkg;

    localparam int PROD_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/vedic_acc_add.sv
// Accumulator adder: zero-extended 24-bit product plus running sum, with carry out.
// Macro VEDIC_ACC_SAT_EN selects clamp-to-all-ones on carry instead of wrapping.
module vedic_acc_add
    import vedic_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry  = w_full[ACC_W];

`ifdef VEDIC_ACC_SAT_EN
    // Once clamped, any further nonzero product carries again, so it stays clamped.
    assign sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/vedic_prod_acc.sv
// Run-length product accumulator: sums len upstream products and holds the result.
// Saturation instead of wrap is enabled by macro VEDIC_ACC_SAT_EN (see vedic_acc_add).
//
// Handshakes: a product moves when prod_valid && prod_ready on a rising edge;
// the result moves when res_valid && res_ready; valid never waits on ready.
module vedic_prod_acc
    import vedic_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              ovf,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               w_xfer;
    logic               w_last;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    vedic_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc   (r_acc),
        .prod  (prod),
        .sum   (w_sum),
        .carry (w_carry)
    );

    assign w_xfer = prod_valid && (r_state == ACC);
    assign w_last = (r_cnt == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = (len == '0) ? HOLD : ACC;
            ACC:  if (w_xfer && w_last) w_state_nxt = HOLD;
            HOLD: if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Start is only honoured in IDLE, so a start coincident with the result
    // handshake (state HOLD) is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_acc <= '0;
            r_cnt <= len;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - LEN_W'(1);
            r_ovf <= r_ovf | w_carry;
        end
    end

    assign prod_ready = (r_state == ACC);
    assign res_valid  = (r_state == HOLD);
    assign busy       = (r_state != IDLE);
    assign res        = r_acc;
    assign ovf        = r_ovf;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_vedic_prod_acc.sv
// Self-checking bench for vedic_prod_acc (ACC_W=24 so wrap/saturation is reachable).
// Expected results are queued at run start and popped at the result handshake.
module tb_vedic_prod_acc;

    localparam int ACC_W = 24;
    localparam int LEN_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              prod_valid = 1'b0;
    logic [23:0]       prod = '0;
    logic              prod_ready;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [ACC_W-1:0]  res;
    logic              ovf;
    logic              busy;
    logic [1:0]        dbg_state;

    int checks = 0;
    int failures = 0;

    logic [ACC_W-1:0] exp_q[$];
    logic             exp_ovf_q[$];
    logic [23:0]      stim_q[$];

    vedic_prod_acc #(
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .ovf        (ovf),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one accepted product.
    function automatic void model_step(inout logic [ACC_W-1:0] a, inout logic o,
                                       input logic [23:0] p);
        logic [ACC_W:0] t;
        t = {1'b0, a} + {{(ACC_W + 1 - 24){1'b0}}, p};
        if (t[ACC_W]) begin
            o = 1'b1;
`ifdef VEDIC_ACC_SAT_EN
            a = {ACC_W{1'b1}};
`else
            a = t[ACC_W-1:0];
`endif
        end else begin
            a = t[ACC_W-1:0];
        end
    endfunction

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        check_eq("start_busy", busy, 1);
        check_eq("start_res_clr", res, 0);
        check_eq("start_ovf_clr", ovf, 0);
        check_eq("start_ready", prod_ready, (l != 0));
        check_eq("start_rvalid", res_valid, (l == 0));
    endtask

    task automatic send_prod(input logic [23:0] p);
        int n = 0;
        prod_valid = 1'b1;
        prod       = p;
        while (!prod_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check_eq("xfer_timeout", 0, 1);
        end else begin
            check_eq("rvalid_in_acc", res_valid, 0);
            @(negedge clk);
        end
        prod_valid = 1'b0;
    endtask

    task automatic wait_res(input int hold, input bit poke);
        int n = 0;
        logic [ACC_W-1:0] e_res;
        logic e_ovf;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_eq("res_timeout", 0, 1);
            return;
        end
        e_res = exp_q.pop_front();
        e_ovf = exp_ovf_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            prod_valid = 1'b1;
            prod       = 24'hABCDEF;
            if (poke) begin
                start = 1'b1;
                len   = 8'd9;
            end
            check_eq("hold_res", res, e_res);
            check_eq("hold_prdy", prod_ready, 0);
            @(negedge clk);
            check_eq("hold_rvalid", res_valid, 1);
        end
        prod_valid = 1'b0;
        check_eq("res", res, e_res);
        check_eq("ovf", ovf, e_ovf);
        res_ready = 1'b1;
        start     = poke;
        len       = poke ? 8'd9 : 8'd0;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        len       = '0;
        check_eq("ret_idle", busy, 0);
        check_eq("ret_rvalid", res_valid, 0);
        @(negedge clk);
        check_eq("stay_idle", busy, 0);
    endtask

    // Runs the products in stim_q as one accumulation run.
    task automatic run(input int gap, input int hold, input bit poke);
        logic [23:0] pq[$];
        logic [ACC_W-1:0] m_acc;
        logic m_ovf;
        logic [ACC_W-1:0] f_acc;
        logic f_ovf;
        pq = stim_q;
        f_acc = '0;
        f_ovf = 1'b0;
        foreach (pq[i]) model_step(f_acc, f_ovf, pq[i]);
        exp_q.push_back(f_acc);
        exp_ovf_q.push_back(f_ovf);
        m_acc = '0;
        m_ovf = 1'b0;
        do_start(pq.size());
        foreach (pq[i]) begin
            for (int g = 0; g < gap; g++) begin
                prod_valid = 1'b0;
                if (poke) begin
                    start = 1'b1;
                    len   = 8'd9;
                end
                @(negedge clk);
                start = 1'b0;
                len   = '0;
                check_eq("gap_res", res, m_acc);
                check_eq("gap_ovf", ovf, m_ovf);
                check_eq("gap_prdy", prod_ready, 1);
            end
            send_prod(pq[i]);
            model_step(m_acc, m_ovf, pq[i]);
        end
        if (pq.size() != 0) begin
            check_eq("lat_rvalid", res_valid, 1);
            check_eq("lat_prdy", prod_ready, 0);
        end
        wait_res(hold, poke);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_res", res, 0);
        check_eq("rst_rvalid", res_valid, 0);
        check_eq("rst_prdy", prod_ready, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", busy, 0);

        stim_q = '{24'd100, 24'd200, 24'd300};
        run(0, 0, 0);

        stim_q = {};
        run(0, 2, 0);

        stim_q = '{24'hFFFFFF, 24'h000002};
        run(0, 0, 0);

        stim_q = '{24'h123456, 24'h0ABCDE};
        run(3, 5, 0);

        stim_q = '{24'd11, 24'd22, 24'd33};
        run(1, 2, 1);

        // Reset mid-run: one of four products accepted, then rst_n pulsed.
        do_start(4);
        send_prod(24'd50);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_res", res, 0);
        check_eq("mid_rst_rvalid", res_valid, 0);
        check_eq("mid_rst_prdy", prod_ready, 0);
        check_eq("mid_rst_ovf", ovf, 0);
        check_eq("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_idle", busy, 0);
        stim_q = '{24'd7};
        run(0, 0, 0);

        // Maximum length run, random products, forces repeated overflow.
        stim_q = {};
        for (int i = 0; i < 255; i++) stim_q.push_back(24'($urandom_range(0, 24'hFFFFFF)));
        run(0, 1, 0);

        for (int k = 0; k < 4; k++) begin
            int l;
            l = $urandom_range(1, 6);
            stim_q = {};
            for (int i = 0; i < l; i++) stim_q.push_back(24'($urandom_range(24'h400000, 24'hFFFFFF)));
            run($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
